// File: rtl/cpu4_program_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu4_program_sequencer_if
// Description : Control, program-load and CPU pin bundle for the 4-bit CPU
//               program sequencer. Signal directions are named from the
//               sequencer's point of view (i_ = into sequencer).
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu4_program_sequencer_if;
   logic        i_ena;
   logic        i_prog_we;
   logic [3:0]  i_prog_addr;
   logic [11:0] i_prog_wdata;
   logic        i_start;
   logic        i_abort;
   logic [3:0]  i_cpu_result_in;
   logic [7:0]  o_cpu_ui_out;
   logic [7:0]  o_cpu_uio_out;
   logic        o_busy;
   logic        o_done;
   logic [3:0]  o_pc;
   logic [3:0]  o_result;
   logic        o_result_valid;
   logic [4:0]  o_instr_count;

   // Host / CPU side: drives control and the CPU result, observes the pins.
   modport master (
      output i_ena, i_prog_we, i_prog_addr, i_prog_wdata, i_start, i_abort,
             i_cpu_result_in,
      input  o_cpu_ui_out, o_cpu_uio_out, o_busy, o_done, o_pc, o_result,
             o_result_valid, o_instr_count
   );

   // Sequencer side.
   modport slave (
      input  i_ena, i_prog_we, i_prog_addr, i_prog_wdata, i_start, i_abort,
             i_cpu_result_in,
      output o_cpu_ui_out, o_cpu_uio_out, o_busy, o_done, o_pc, o_result,
             o_result_valid, o_instr_count
   );
endinterface
`default_nettype wire

// File: rtl/cpu4_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu4_program_sequencer
// Description : Holds a 16-entry program and replays it onto the pins of the
//               4-bit accumulator CPU, pacing each opcode so the CPU's
//               execute FSM completes, then captures the returned result.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu4_program_sequencer #(
   parameter int unsigned ISSUE_CYCLES = 3,
   parameter int unsigned GAP_CYCLES   = 1,
   parameter logic [3:0]  HALT_OPCODE  = 4'b1111,
   parameter logic [3:0]  NOP_OPCODE   = 4'b1011
) (
   input  wire logic               clk,
   input  wire logic               rst_n,
   cpu4_program_sequencer_if.slave bus
);

   // Shared issue/gap counter runs 0 .. max(ISSUE,GAP)-1.
   localparam int unsigned c_MAX_CYC = (ISSUE_CYCLES > GAP_CYCLES) ? ISSUE_CYCLES : GAP_CYCLES;
   localparam int unsigned c_CNT_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;
   localparam logic [c_CNT_W-1:0] c_ISSUE_LAST   = c_CNT_W'(ISSUE_CYCLES - 1);
   localparam logic [c_CNT_W-1:0] c_GAP_LAST     = c_CNT_W'(GAP_CYCLES - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE      = c_CNT_W'(1);
   localparam logic [3:0]         c_STORE_OPCODE = 4'b0010;
   localparam logic [7:0]         c_NOP_UIO      = {NOP_OPCODE, 4'b0000};
   localparam logic [11:0]        c_HALT_ENTRY   = {HALT_OPCODE, 8'h00};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_ISSUE = 3'd2,
      S_GAP   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t               r_state,        w_state_nx;
   logic [3:0]           r_pc,           w_pc_nx;
   logic [c_CNT_W-1:0]   r_cnt,          w_cnt_nx;
   logic [3:0]           r_result,       w_result_nx;
   logic                 r_result_valid, w_result_valid_nx;
   logic [4:0]           r_instr_count,  w_instr_count_nx;
   logic [7:0]           r_ui,           w_ui_nx;
   logic [7:0]           r_uio,          w_uio_nx;
   logic                 r_busy,         w_busy_nx;
   logic                 r_done,         w_done_nx;

   logic [11:0]          r_mem [16];
   logic [11:0]          w_fetch;
   logic                 w_mem_we;

   assign w_fetch  = r_mem[r_pc];
   // Loading is locked out during a run so the executing program cannot change.
   assign w_mem_we = bus.i_ena && bus.i_prog_we && !r_busy;

   // Program memory: reset fills every slot with HALT so an unloaded program ends at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            r_mem[i] <= c_HALT_ENTRY;
         end
      end else if (w_mem_we) begin
         r_mem[bus.i_prog_addr] <= bus.i_prog_wdata;
      end
   end

   // Next-state and next-output decode; pins are loaded on the same edge as the state change.
   always_comb begin
      w_state_nx        = r_state;
      w_pc_nx           = r_pc;
      w_cnt_nx          = r_cnt;
      w_result_nx       = r_result;
      w_result_valid_nx = 1'b0;
      w_instr_count_nx  = r_instr_count;
      w_ui_nx           = r_ui;
      w_uio_nx          = r_uio;

      if (bus.i_abort) begin
         w_state_nx = S_IDLE;
         w_uio_nx   = c_NOP_UIO;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (bus.i_start) begin
                  w_state_nx       = S_FETCH;
                  w_pc_nx          = 4'd0;
                  w_instr_count_nx = 5'd0;
               end
            end
            S_FETCH: begin
               if (w_fetch[11:8] == HALT_OPCODE) begin
                  w_state_nx = S_DONE;
               end else begin
                  w_state_nx = S_ISSUE;
                  w_cnt_nx   = '0;
                  w_ui_nx    = w_fetch[7:0];
                  w_uio_nx   = {w_fetch[11:8], 3'b000, (w_fetch[11:8] == c_STORE_OPCODE)};
               end
            end
            S_ISSUE: begin
               if (r_cnt == c_ISSUE_LAST) begin
                  w_state_nx        = S_GAP;
                  w_cnt_nx          = '0;
                  w_result_nx       = bus.i_cpu_result_in;
                  w_result_valid_nx = 1'b1;
                  w_instr_count_nx  = r_instr_count + 5'd1;
                  w_uio_nx          = c_NOP_UIO;
               end else begin
                  w_cnt_nx = r_cnt + c_CNT_ONE;
               end
            end
            S_GAP: begin
               if (r_cnt == c_GAP_LAST) begin
                  // The last slot ends the run; the pc never wraps back to 0.
                  if (r_pc == 4'd15) begin
                     w_state_nx = S_DONE;
                  end else begin
                     w_state_nx = S_FETCH;
                     w_pc_nx    = r_pc + 4'd1;
                  end
               end else begin
                  w_cnt_nx = r_cnt + c_CNT_ONE;
               end
            end
            default: begin
               w_state_nx = S_IDLE;
               w_uio_nx   = c_NOP_UIO;
            end
         endcase
      end

      w_busy_nx = (w_state_nx == S_FETCH) || (w_state_nx == S_ISSUE) || (w_state_nx == S_GAP);
      w_done_nx = (w_state_nx == S_DONE);
   end

   // State and output registers; ena low freezes everything except the result pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_pc           <= 4'd0;
         r_cnt          <= '0;
         r_result       <= 4'd0;
         r_result_valid <= 1'b0;
         r_instr_count  <= 5'd0;
         r_ui           <= 8'h00;
         r_uio          <= c_NOP_UIO;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
      end else if (bus.i_ena) begin
         r_state        <= w_state_nx;
         r_pc           <= w_pc_nx;
         r_cnt          <= w_cnt_nx;
         r_result       <= w_result_nx;
         r_result_valid <= w_result_valid_nx;
         r_instr_count  <= w_instr_count_nx;
         r_ui           <= w_ui_nx;
         r_uio          <= w_uio_nx;
         r_busy         <= w_busy_nx;
         r_done         <= w_done_nx;
      end else begin
         r_result_valid <= 1'b0;
      end
   end

   assign bus.o_cpu_ui_out   = r_ui;
   assign bus.o_cpu_uio_out  = r_uio;
   assign bus.o_busy         = r_busy;
   assign bus.o_done         = r_done;
   assign bus.o_pc           = r_pc;
   assign bus.o_result       = r_result;
   assign bus.o_result_valid = r_result_valid;
   assign bus.o_instr_count  = r_instr_count;

endmodule
`default_nettype wire
